padded_window_reader: RTL and testbench
=======================================

PADDED_WINDOW_READER -- requirements
Module: padded_window_reader

Interface
REQ-001 Parameter PE, default 16: channels per buffer word; word width PE*8 bits.
REQ-002 Parameter ADDR_STEP, default 4: address increment per buffer word.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 start  input  1  one-cycle request to begin a scan; sampled only in IDLE.
REQ-006 IFM_C  input  8  channels of the padded map stored in the buffer; multiple of PE.
REQ-007 IFM_W  input  8  padded width (equal to padded height) of the stored map.
REQ-008 KERNEL  input  2  kernel size; legal values 1 and 3.
REQ-009 STRIDE  input  2  stride; legal values 1 and 2.
REQ-010 base_addr  input  16  buffer address of padded pixel (0,0), channel group 0.
REQ-011 rd_ready  input  1  downstream PE array accepts a word this cycle.
REQ-012 rd_en  output  1  buffer read strobe.
REQ-013 rd_addr  output  16  buffer read address, valid while rd_en=1.
REQ-014 mem_data  input  PE*8  buffer read data, valid one cycle after rd_en.
REQ-015 data_out  output  PE*8  registered window word to PE array.
REQ-016 data_valid  output  1  data_out valid.
REQ-017 win_last  output  1  data_out is the final word of the current window.
REQ-018 busy  output  1  high in every state except IDLE.
REQ-019 done  output  1  one-cycle pulse marking scan completion.

Function
REQ-020 FSM states SHALL be IDLE, RUN, DRAIN; IDLE->RUN on start; RUN->DRAIN after final read issued; DRAIN->IDLE after final data_valid.
REQ-021 On start, CG=IFM_C/PE, K, S, Wp=IFM_W and base_addr SHALL be latched; later input changes do not affect the scan.
REQ-022 Output size Wo=(Wp-K)/S+1, integer division; window count Wo*Wo.
REQ-023 Loop order outermost to innermost SHALL be oy, ox, ky, kx, cg; each index spans 0..Wo-1, 0..Wo-1, 0..K-1, 0..K-1, 0..CG-1.
REQ-024 Word index = ((oy*S+ky)*Wp + ox*S+kx)*CG + cg; rd_addr = base_addr + ADDR_STEP*index, computed in 32 bits, truncated to 16 (wraps modulo 2^16).
REQ-025 rd_en = (state==RUN) && rd_ready; the counters advance only on cycles with rd_en=1; rd_ready=0 holds rd_addr and all counters.
REQ-026 First rd_en SHALL be possible in the cycle after start is sampled.
REQ-027 data_out/data_valid SHALL register mem_data two cycles after the matching rd_en; win_last SHALL register (ky==K-1 && kx==K-1 && cg==CG-1) with the same delay.
REQ-028 done SHALL pulse in the cycle of the final data_valid; state returns to IDLE the next cycle.
REQ-029 start while busy SHALL be ignored.
REQ-030 Degenerate setup (CG==0, Wp<K, or KERNEL/STRIDE illegal) SHALL issue zero reads and pulse done in the cycle after start.

Reset
REQ-031 With rst=1 on an edge: state=IDLE, all counters 0, rd_en, data_valid, win_last, busy, done=0, data_out=0, rd_addr=0.
REQ-032 Reset mid-scan SHALL abort with no further reads; in-flight mem_data SHALL be discarded.

Structure
REQ-033 State enum, legal KERNEL/STRIDE constants and ADDR_STEP default SHALL reside in the shared accelerator package.
REQ-034 The five-level index nest with carry logic SHALL be one sub-module, window_addr_counter; the FSM and data pipeline stay in the top module.

Verification
REQ-035 C=16,W=4,K=3,S=1,base 0, rd_ready=1 -> 36 reads; first window addresses 0,4,8,16,20,24,32,36,40; win_last on words 9,18,27,36; one done.
REQ-036 C=32,W=2,K=1,S=1 -> 8 reads, addresses 0,4,...,28; win_last on every second word.
REQ-037 C=16,W=5,K=3,S=2 -> 4 windows; window starts at addresses 0,8,40,48.
REQ-038 REQ-035 setup with rd_ready toggling every cycle -> identical address sequence, no duplicates, rd_en=0 whenever rd_ready=0.
REQ-039 rst asserted during read 10 of REQ-035 -> all outputs 0 next cycle, no done; new start restarts at address 0.
REQ-040 W=2,K=3 -> zero reads, done one cycle after start; start pulsed while busy -> no second scan.

Source files
------------

// File: rtl/padded_window_reader_pkg.sv
// padded_window_reader_pkg: shared accelerator types and constants for the padded window reader
//   state_t        : scan FSM states
//   KERNEL_*/STRIDE_* : legal kernel sizes and strides
//   ADDR_STEP_DEF  : default buffer address increment per word
//   cfg_legal()    : true when a kernel/stride pair is supported
package padded_window_reader_pkg;
    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DRAIN} state_t;
    localparam logic [1:0] KERNEL_1 = 2'd1;
    localparam logic [1:0] KERNEL_3 = 2'd3;
    localparam logic [1:0] STRIDE_1 = 2'd1;
    localparam logic [1:0] STRIDE_2 = 2'd2;
    localparam int ADDR_STEP_DEF = 4;
    function automatic logic cfg_legal(input logic [1:0] k, input logic [1:0] s);
        return (k == KERNEL_1 || k == KERNEL_3) && (s == STRIDE_1 || s == STRIDE_2);
    endfunction
endpackage

// File: rtl/padded_window_reader_if.sv
// padded_window_reader_if: scan configuration, buffer read port and PE-array output bundle
//   master : scan requester / buffer / PE array side
//   slave  : padded_window_reader side
interface padded_window_reader_if #(parameter int PE = 16);
    import padded_window_reader_pkg::*;
    logic            start;
    logic [7:0]      ifm_c;
    logic [7:0]      ifm_w;
    logic [1:0]      kernel;
    logic [1:0]      stride;
    logic [15:0]     base_addr;
    logic            rd_ready;
    logic            rd_en;
    logic [15:0]     rd_addr;
    logic [PE*8-1:0] mem_data;
    logic [PE*8-1:0] data_out;
    logic            data_valid;
    logic            win_last;
    logic            busy;
    logic            done;
    modport master (
        output start, ifm_c, ifm_w, kernel, stride, base_addr, rd_ready, mem_data,
        input  rd_en, rd_addr, data_out, data_valid, win_last, busy, done
    );
    modport slave (
        input  start, ifm_c, ifm_w, kernel, stride, base_addr, rd_ready, mem_data,
        output rd_en, rd_addr, data_out, data_valid, win_last, busy, done
    );
endinterface

// File: rtl/padded_window_reader_window_addr_counter.sv
// window_addr_counter: five-level oy/ox/ky/kx/cg index nest and buffer address generator
//   clk, rst     : clock, synchronous active-high reset
//   i_clear      : zero all indices (scan start)
//   i_adv        : step the innermost index, carrying outward
//   i_cg..i_base : latched scan geometry (channel groups, padded width, output width, K, S, base)
//   o_addr       : buffer address of the current word
//   o_win_last   : current word closes its window
//   o_final      : current word is the last of the scan
module window_addr_counter
    import padded_window_reader_pkg::*;
#(
    parameter int ADDR_STEP = ADDR_STEP_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_clear,
    input  logic        i_adv,
    input  logic [7:0]  i_cg,
    input  logic [7:0]  i_wp,
    input  logic [7:0]  i_wo,
    input  logic [1:0]  i_k,
    input  logic [1:0]  i_s,
    input  logic [15:0] i_base,
    output logic [15:0] o_addr,
    output logic        o_win_last,
    output logic        o_final
);
    logic [7:0]  r_cg, r_ox, r_oy;
    logic [1:0]  r_kx, r_ky;
    logic        w_cg_end, w_kx_end, w_ky_end, w_ox_end, w_oy_end;
    logic        w_c1, w_c2, w_c3;
    logic [31:0] w_idx, w_addr;

    always_comb begin
        w_cg_end   = r_cg == i_cg - 8'd1;
        w_kx_end   = r_kx == i_k - 2'd1;
        w_ky_end   = r_ky == i_k - 2'd1;
        w_ox_end   = r_ox == i_wo - 8'd1;
        w_oy_end   = r_oy == i_wo - 8'd1;
        // carry chain: each level wraps only when every inner level is at its end
        w_c1       = w_cg_end && w_kx_end;
        w_c2       = w_c1 && w_ky_end;
        w_c3       = w_c2 && w_ox_end;
        o_win_last = w_c2;
        o_final    = w_c3 && w_oy_end;
        w_idx      = ((32'(r_oy) * 32'(i_s) + 32'(r_ky)) * 32'(i_wp)
                     + 32'(r_ox) * 32'(i_s) + 32'(r_kx)) * 32'(i_cg) + 32'(r_cg);
        w_addr     = 32'(i_base) + 32'(ADDR_STEP) * w_idx;
        o_addr     = w_addr[15:0];
    end

    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_cg <= '0;
            r_kx <= '0;
            r_ky <= '0;
            r_ox <= '0;
            r_oy <= '0;
        end else if (i_adv) begin
            r_cg <= w_cg_end ? '0 : r_cg + 8'd1;
            if (w_cg_end) r_kx <= w_kx_end ? '0 : r_kx + 2'd1;
            if (w_c1)     r_ky <= w_ky_end ? '0 : r_ky + 2'd1;
            if (w_c2)     r_ox <= w_ox_end ? '0 : r_ox + 8'd1;
            if (w_c3)     r_oy <= w_oy_end ? '0 : r_oy + 8'd1;
        end
    end
endmodule

// File: rtl/padded_window_reader.sv
// padded_window_reader: scans a padded feature map in a buffer window by window and streams words to a PE array
//   clk, rst : clock, synchronous active-high reset
//   bus      : scan request/config, buffer read port (rd_en/rd_addr/mem_data),
//              PE output (data_out/data_valid/win_last), status (busy/done)
module padded_window_reader
    import padded_window_reader_pkg::*;
#(
    parameter int PE        = 16,
    parameter int ADDR_STEP = ADDR_STEP_DEF
) (
    input logic                   clk,
    input logic                   rst,
    padded_window_reader_if.slave bus
);
    state_t          r_state, w_state_nxt;
    logic [7:0]      r_cg, r_wp, r_wo;
    logic [1:0]      r_k, r_s;
    logic [15:0]     r_base;
    logic [7:0]      w_cg_in, w_span, w_wo_in;
    logic            w_start, w_degen, w_rd_en, w_win_last, w_final;
    logic [15:0]     w_addr;
    logic            r_p1_valid, r_p1_win_last, r_p1_final;
    logic [PE*8-1:0] r_data;
    logic            r_valid, r_win_last, r_done;

    assign w_start = (r_state == ST_IDLE) && bus.start;
    assign w_cg_in = 8'(32'(bus.ifm_c) / 32'(PE));
    assign w_degen = (w_cg_in == 8'd0) || (bus.ifm_w < 8'(bus.kernel)) || !cfg_legal(bus.kernel, bus.stride);
    assign w_span  = bus.ifm_w - 8'(bus.kernel);
    assign w_wo_in = ((bus.stride == STRIDE_2) ? (w_span >> 1) : w_span) + 8'd1;

    always_comb begin
        w_rd_en     = (r_state == ST_RUN) && bus.rd_ready;
        w_state_nxt = r_state;
        // a degenerate setup never leaves IDLE; its done pulse comes straight from the start cycle
        w_state_nxt = (w_start && !w_degen)                 ? ST_RUN   :
                      (r_state == ST_RUN && w_rd_en && w_final) ? ST_DRAIN :
                      (r_state == ST_DRAIN && r_done)          ? ST_IDLE  : r_state;
    end

    window_addr_counter #(.ADDR_STEP(ADDR_STEP)) u_cnt (
        .clk       (clk),
        .rst       (rst),
        .i_clear   (w_start),
        .i_adv     (w_rd_en),
        .i_cg      (r_cg),
        .i_wp      (r_wp),
        .i_wo      (r_wo),
        .i_k       (r_k),
        .i_s       (r_s),
        .i_base    (r_base),
        .o_addr    (w_addr),
        .o_win_last(w_win_last),
        .o_final   (w_final)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_cg          <= '0;
            r_wp          <= '0;
            r_wo          <= '0;
            r_k           <= '0;
            r_s           <= '0;
            r_base        <= '0;
            r_p1_valid    <= 1'b0;
            r_p1_win_last <= 1'b0;
            r_p1_final    <= 1'b0;
            r_data        <= '0;
            r_valid       <= 1'b0;
            r_win_last    <= 1'b0;
            r_done        <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_start) begin
                r_cg   <= w_cg_in;
                r_wp   <= bus.ifm_w;
                r_wo   <= w_wo_in;
                r_k    <= bus.kernel;
                r_s    <= bus.stride;
                r_base <= bus.base_addr;
            end
            // stage 1 tracks the read whose data arrives next cycle; stage 2 captures that data
            r_p1_valid    <= w_rd_en;
            r_p1_win_last <= w_rd_en && w_win_last;
            r_p1_final    <= w_rd_en && w_final;
            if (r_p1_valid) r_data <= bus.mem_data;
            r_valid       <= r_p1_valid;
            r_win_last    <= r_p1_win_last;
            r_done        <= (r_p1_valid && r_p1_final) || (w_start && w_degen);
        end
    end

    assign bus.rd_en      = w_rd_en;
    assign bus.rd_addr    = w_addr;
    assign bus.data_out   = r_data;
    assign bus.data_valid = r_valid;
    assign bus.win_last   = r_win_last;
    assign bus.busy       = r_state != ST_IDLE;
    assign bus.done       = r_done;
endmodule

// File: tb/tb_padded_window_reader.sv
// tb_padded_window_reader: scoreboard bench for padded_window_reader
module tb_padded_window_reader;
    localparam int PE = 16;

    typedef struct packed {logic [15:0] addr; logic wl;} rd_t;
    typedef struct packed {logic [PE*8-1:0] data; logic wl;} out_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;

    padded_window_reader_if #(.PE(PE)) bus ();
    padded_window_reader #(.PE(PE)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [PE*8-1:0] word_of(input logic [15:0] a);
        return {(PE/2){a ^ 16'h5A3C}};
    endfunction

    always @(posedge clk) bus.mem_data <= bus.rd_en ? word_of(bus.rd_addr) : {PE{8'hEE}};

    int          n_checks = 0;
    int          n_fail   = 0;
    rd_t         exp_rd[$];
    out_t        pipe[$];
    logic [15:0] got_addr[$];
    int          wl_pos[$];
    int          exp_total, rd_cnt, out_cnt, done_cnt, done_cyc, first_rd_cyc, start_cyc;
    bit          prev_done, mon_en;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [15:0] addr_at(input int i);
        return i < got_addr.size() ? got_addr[i] : 16'hDEAD;
    endfunction

    function automatic int wl_at(input int i);
        return i < wl_pos.size() ? wl_pos[i] : -1;
    endfunction

    task automatic monitor();
        rd_t  r;
        out_t o;
        if (bus.rd_en) begin
            if (rd_cnt == 0) first_rd_cyc = cyc;
            rd_cnt++;
            got_addr.push_back(bus.rd_addr);
            if (exp_rd.size() == 0) chk("extra_read", rd_cnt, exp_total);
            else begin
                r = exp_rd.pop_front();
                chk("rd_addr", bus.rd_addr, r.addr);
                o.data = word_of(r.addr);
                o.wl   = r.wl;
                pipe.push_back(o);
            end
        end
        if (!bus.rd_ready) chk("rd_en_gate", bus.rd_en, 0);
        if (bus.data_valid) begin
            out_cnt++;
            if (bus.win_last) wl_pos.push_back(out_cnt);
            if (pipe.size() == 0) chk("spurious_valid", out_cnt, exp_total);
            else begin
                o = pipe.pop_front();
                chk("data_out", bus.data_out, o.data);
                chk("win_last", bus.win_last, o.wl);
            end
        end
        if (prev_done) chk("idle_after_done", bus.busy, 0);
        if (bus.done) begin
            done_cnt++;
            done_cyc = cyc;
            chk("done_on_last", bus.data_valid, exp_total != 0);
            chk("done_drained", exp_rd.size() + pipe.size(), 0);
        end
        prev_done = bus.done;
    endtask

    initial forever begin
        @(negedge clk);
        if (mon_en) monitor();
    end

    task automatic prep(input int c, input int w, input int k, input int s, input int base);
        int  cgn, wo;
        rd_t r;
        exp_rd.delete(); pipe.delete(); got_addr.delete(); wl_pos.delete();
        rd_cnt = 0; out_cnt = 0; done_cnt = 0; done_cyc = -1; first_rd_cyc = -1; prev_done = 0;
        cgn = c / PE;
        if (cgn != 0 && w >= k && (k == 1 || k == 3) && (s == 1 || s == 2)) begin
            wo = (w - k) / s + 1;
            for (int oy = 0; oy < wo; oy++)
                for (int ox = 0; ox < wo; ox++)
                    for (int ky = 0; ky < k; ky++)
                        for (int kx = 0; kx < k; kx++)
                            for (int g = 0; g < cgn; g++) begin
                                r.addr = 16'(base + 4 * (((oy * s + ky) * w + ox * s + kx) * cgn + g));
                                r.wl   = (ky == k - 1) && (kx == k - 1) && (g == cgn - 1);
                                exp_rd.push_back(r);
                            end
        end
        exp_total     = exp_rd.size();
        bus.ifm_c     = 8'(c);
        bus.ifm_w     = 8'(w);
        bus.kernel    = 2'(k);
        bus.stride    = 2'(s);
        bus.base_addr = 16'(base);
        bus.rd_ready  = 1'b1;
    endtask

    task automatic launch();
        @(posedge clk); #1;
        bus.start = 1'b1;
        @(posedge clk); #1;
        start_cyc     = cyc;
        bus.start     = 1'b0;
        bus.ifm_c     = 8'hFF;
        bus.ifm_w     = 8'd0;
        bus.kernel    = 2'd0;
        bus.stride    = 2'd0;
        bus.base_addr = 16'hFFFF;
    endtask

    task automatic run_scan(input int c, input int w, input int k, input int s, input int base,
                            input bit toggle, input bit rebusy);
        int n = 0;
        prep(c, w, k, s, base);
        launch();
        while (done_cnt == 0 && n < 2000) begin
            if (toggle) bus.rd_ready = ~bus.rd_ready;
            bus.start = rebusy && n == 3;
            @(posedge clk); #1;
            n++;
        end
        if (done_cnt == 0) chk("done_timeout", done_cnt, 1);
        bus.start    = 1'b0;
        bus.rd_ready = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        chk("reads", rd_cnt, exp_total);
        chk("done_count", done_cnt, 1);
        chk("busy_idle", bus.busy, 0);
        chk("sb_empty", exp_rd.size() + pipe.size(), 0);
        if (exp_total == 0) chk("deg_done_lat", done_cyc - start_cyc, 0);
        else if (!toggle) chk("first_rd_lat", first_rd_cyc - start_cyc, 0);
    endtask

    initial begin
        int w0[9] = '{0, 4, 8, 16, 20, 24, 32, 36, 40};
        int ws[4] = '{0, 8, 40, 48};
        bus.start = 1'b0; bus.rd_ready = 1'b1; bus.ifm_c = 8'd16; bus.ifm_w = 8'd4;
        bus.kernel = 2'd3; bus.stride = 2'd1; bus.base_addr = 16'd0;
        mon_en = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ctrl", {bus.rd_en, bus.data_valid, bus.win_last, bus.busy, bus.done}, 0);
        chk("rst_addr", bus.rd_addr, 0);
        chk("rst_data", bus.data_out, 0);
        rst = 1'b0;
        mon_en = 1'b1;

        run_scan(16, 4, 3, 1, 0, 0, 0);
        for (int i = 0; i < 9; i++) chk("w0_addr", addr_at(i), w0[i]);
        chk("wl_count_3x3", wl_pos.size(), 4);
        for (int i = 0; i < 4; i++) chk("wl_pos_3x3", wl_at(i), 9 * (i + 1));

        run_scan(32, 2, 1, 1, 0, 0, 0);
        for (int i = 0; i < 8; i++) chk("k1_addr", addr_at(i), 4 * i);
        chk("wl_count_k1", wl_pos.size(), 4);
        for (int i = 0; i < 4; i++) chk("wl_pos_k1", wl_at(i), 2 * (i + 1));

        run_scan(16, 5, 3, 2, 0, 0, 1);
        for (int i = 0; i < 4; i++) chk("s2_win_start", addr_at(9 * i), ws[i]);

        run_scan(16, 4, 3, 1, 0, 1, 0);
        run_scan(16, 4, 3, 1, 16'hFFF0, 0, 0);

        prep(16, 4, 3, 1, 0);
        launch();
        repeat (9) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        mon_en = 1'b0;
        chk("abort_reads", rd_cnt, 10);
        @(negedge clk);
        chk("abort_ctrl", {bus.rd_en, bus.data_valid, bus.win_last, bus.busy, bus.done}, 0);
        chk("abort_addr", bus.rd_addr, 0);
        chk("abort_data", bus.data_out, 0);
        repeat (3) begin
            @(negedge clk);
            chk("abort_quiet", {bus.rd_en, bus.data_valid, bus.done, bus.busy}, 0);
        end
        @(posedge clk); #1;
        mon_en = 1'b1;
        run_scan(16, 4, 3, 1, 0, 0, 0);
        chk("restart_addr0", addr_at(0), 0);

        run_scan(16, 2, 3, 1, 0, 0, 0);
        run_scan(16, 4, 2, 1, 0, 0, 0);
        run_scan(8, 4, 3, 1, 0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1);
    end
endmodule
